// File: rtl/core_excp_ctrl_pkg.sv
// Shared types and constants for the commit-stage exception controller.
package core_excp_ctrl_pkg;

  // Controller phase; the flush counter lives beside it
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  localparam int unsigned DEF_EXCP_W    = 16;
  localparam int unsigned DEF_TLBR_BIT  = 14;
  localparam int unsigned DEF_ITLBR_BIT = 15;
  localparam int unsigned CNT_W         = 4;

  // Interrupts are reported in the top slot of the exception vector
  localparam int unsigned INT_ECODE_IDX = DEF_EXCP_W - 1;

  function automatic int unsigned int_ecode_idx(input int unsigned excp_w);
    return excp_w - 1;
  endfunction

endpackage

// File: rtl/core_excp_ctrl_if.sv
// Commit-lane inputs and redirect/CSR-update outputs of the exception controller.
interface core_excp_ctrl_if
  import core_excp_ctrl_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned EXCP_W = DEF_EXCP_W
);
  localparam int unsigned ECODE_W = $clog2(EXCP_W);

  logic [LANES-1:0]             valid_i;
  logic [LANES-1:0][EXCP_W-1:0] excp_i;
  logic [LANES-1:0]             ertn_i;
  logic [LANES-1:0]             idle_i;
  logic [LANES-1:0][31:0]       pc_i;
  logic [31:0]                  eentry_i;
  logic [31:0]                  tlbrentry_i;
  logic [31:0]                  era_i;
  logic                         int_pending_i;

  logic [LANES-1:0]             commit_mask_o;
  logic                         redirect_o;
  logic [31:0]                  target_o;
  logic                         excp_commit_o;
  logic                         ertn_commit_o;
  logic [ECODE_W-1:0]           ecode_idx_o;
  logic [31:0]                  era_o;
  logic                         idle_o;

  modport master (
    output valid_i, excp_i, ertn_i, idle_i, pc_i,
    output eentry_i, tlbrentry_i, era_i, int_pending_i,
    input  commit_mask_o, redirect_o, target_o, excp_commit_o,
    input  ertn_commit_o, ecode_idx_o, era_o, idle_o
  );

  modport slave (
    input  valid_i, excp_i, ertn_i, idle_i, pc_i,
    input  eentry_i, tlbrentry_i, era_i, int_pending_i,
    output commit_mask_o, redirect_o, target_o, excp_commit_o,
    output ertn_commit_o, ecode_idx_o, era_o, idle_o
  );

endinterface

// File: rtl/core_excp_lane_sel.sv
// Lowest-index priority selector: one-hot grant, binary index and any-hit flag.
module core_excp_lane_sel #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_onehot_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  // Scan from the top so the lowest requesting index is the last one written
  always_comb begin
    o_onehot_c = '0;
    o_idx_c    = '0;
    o_any_c    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_onehot_c    = '0;
        o_onehot_c[i] = 1'b1;
        o_idx_c       = IDX_W'(i);
        o_any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_excp_ctrl.sv
// Commit-stage exception/ertn/idle controller: gates commit lanes, issues redirects.
module core_excp_ctrl
  import core_excp_ctrl_pkg::*;
#(
  parameter int unsigned LANES        = 2,
  parameter int unsigned EXCP_W       = DEF_EXCP_W,
  parameter int unsigned TLBR_BIT     = DEF_TLBR_BIT,
  parameter int unsigned ITLBR_BIT    = DEF_ITLBR_BIT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  core_excp_ctrl_if.slave bus
);

  localparam int unsigned ECODE_W   = $clog2(EXCP_W);
  localparam int unsigned LIDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ECODE_INT = int_ecode_idx(EXCP_W);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_redirect, w_redirect_nxt;
  logic               r_excp_commit, w_excp_commit_nxt;
  logic               r_ertn_commit, w_ertn_commit_nxt;
  logic [31:0]        r_target, w_target_nxt;
  logic [31:0]        r_era, w_era_nxt;
  logic [ECODE_W-1:0] r_ecode, w_ecode_nxt;
  logic               r_idle, w_idle_nxt;
  logic [31:0]        r_idle_pc, w_idle_pc_nxt;

  logic [LANES-1:0]   w_trap, w_idle_lane, w_req;
  logic               w_int;
  logic [LANES-1:0]   w_sel_oh, w_below, w_run_mask;
  logic [LIDX_W-1:0]  w_sel_idx;
  logic               w_sel_any;
  logic [EXCP_W-1:0]  w_sel_excp;
  logic               w_sel_ertn;
  logic [31:0]        w_sel_pc;
  logic               w_kind_excp, w_kind_ertn, w_kind_idle;
  logic [ECODE_W-1:0] w_ecode;
  logic [31:0]        w_trap_target;

  // Classify each lane as trapping or idling
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      w_trap[l]      = bus.valid_i[l] & ((|bus.excp_i[l]) | bus.ertn_i[l]);
      w_idle_lane[l] = bus.valid_i[l] & bus.idle_i[l] & ~(|bus.excp_i[l]);
    end
  end

  // A pending interrupt claims lane 0 whenever it holds an instruction
  assign w_int = bus.int_pending_i & bus.valid_i[0];
  assign w_req = w_trap | w_idle_lane | LANES'(w_int);

  core_excp_lane_sel #(
    .N     (LANES),
    .IDX_W (LIDX_W)
  ) u_lane_sel (
    .i_req      (w_req),
    .o_onehot_c (w_sel_oh),
    .o_idx_c    (w_sel_idx),
    .o_any_c    (w_sel_any)
  );

  assign w_sel_excp = bus.excp_i[w_sel_idx];
  assign w_sel_ertn = bus.ertn_i[w_sel_idx];
  assign w_sel_pc   = bus.pc_i[w_sel_idx];

  // Interrupt beats flags, flags beat ertn, anything else selected is idle
  assign w_kind_excp = w_int | (|w_sel_excp);
  assign w_kind_ertn = ~w_kind_excp & w_sel_ertn;
  assign w_kind_idle = ~w_kind_excp & ~w_sel_ertn;

  // Lowest set exception flag of the selected lane
  always_comb begin
    w_ecode = '0;
    for (int i = int'(EXCP_W) - 1; i >= 0; i--) begin
      if (w_sel_excp[i]) w_ecode = ECODE_W'(i);
    end
  end

  // Redirect target for a trap taken in RUN
  always_comb begin
    if (w_kind_ertn)
      w_trap_target = bus.era_i;
    else if (!w_int && (w_sel_excp[TLBR_BIT] || w_sel_excp[ITLBR_BIT]))
      w_trap_target = bus.tlbrentry_i;
    else
      w_trap_target = bus.eentry_i;
  end

  // Older lanes commit; the selected lane commits only if it is ertn or idle
  assign w_below = w_sel_oh - LANES'(1);
  always_comb begin
    if (!w_sel_any)
      w_run_mask = bus.valid_i;
    else if (w_int)
      w_run_mask = '0;
    else
      w_run_mask = bus.valid_i & (w_below | (w_sel_oh & {LANES{~w_kind_excp}}));
  end

  // Next-state, commit mask and next values of the registered outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_redirect_nxt    = 1'b0;
    w_excp_commit_nxt = 1'b0;
    w_ertn_commit_nxt = 1'b0;
    w_target_nxt      = r_target;
    w_era_nxt         = r_era;
    w_ecode_nxt       = r_ecode;
    w_idle_nxt        = 1'b0;
    w_idle_pc_nxt     = r_idle_pc;
    bus.commit_mask_o = '0;
    case (r_state)
      ST_RUN: begin
        bus.commit_mask_o = w_run_mask;
        if (w_sel_any) begin
          if (w_kind_idle) begin
            w_state_nxt   = ST_IDLE;
            w_idle_nxt    = 1'b1;
            w_idle_pc_nxt = w_sel_pc + 32'd4;
          end else begin
            w_state_nxt       = ST_FLUSH;
            w_cnt_nxt         = CNT_W'(FLUSH_CYCLES - 1);
            w_redirect_nxt    = 1'b1;
            w_excp_commit_nxt = w_kind_excp;
            w_ertn_commit_nxt = w_kind_ertn;
            w_target_nxt      = w_trap_target;
            w_era_nxt         = w_sel_pc;
            w_ecode_nxt       = w_int ? ECODE_W'(ECODE_INT) : w_ecode;
          end
        end
      end
      ST_IDLE: begin
        w_idle_nxt = 1'b1;
        if (bus.int_pending_i) begin
          w_state_nxt       = ST_FLUSH;
          w_cnt_nxt         = CNT_W'(FLUSH_CYCLES - 1);
          w_idle_nxt        = 1'b0;
          w_redirect_nxt    = 1'b1;
          w_excp_commit_nxt = 1'b1;
          w_target_nxt      = bus.eentry_i;
          w_era_nxt         = r_idle_pc;
          w_ecode_nxt       = ECODE_W'(ECODE_INT);
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = ST_RUN;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_redirect    <= 1'b0;
      r_excp_commit <= 1'b0;
      r_ertn_commit <= 1'b0;
      r_target      <= '0;
      r_era         <= '0;
      r_ecode       <= '0;
      r_idle        <= 1'b0;
      r_idle_pc     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_redirect    <= w_redirect_nxt;
      r_excp_commit <= w_excp_commit_nxt;
      r_ertn_commit <= w_ertn_commit_nxt;
      r_target      <= w_target_nxt;
      r_era         <= w_era_nxt;
      r_ecode       <= w_ecode_nxt;
      r_idle        <= w_idle_nxt;
      r_idle_pc     <= w_idle_pc_nxt;
    end
  end

  assign bus.redirect_o    = r_redirect;
  assign bus.excp_commit_o = r_excp_commit;
  assign bus.ertn_commit_o = r_ertn_commit;
  assign bus.target_o      = r_target;
  assign bus.era_o         = r_era;
  assign bus.ecode_idx_o   = r_ecode;
  assign bus.idle_o        = r_idle;

endmodule

// File: tb/tb_core_excp_ctrl.sv
// Scoreboard bench for core_excp_ctrl with LANES=2, EXCP_W=16, FLUSH_CYCLES=2.
module tb_core_excp_ctrl;
  import core_excp_ctrl_pkg::*;

  localparam int unsigned LANES        = 2;
  localparam int unsigned EXCP_W       = 16;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] EENTRY       = 32'h1C00_8000;
  localparam logic [31:0] TLBRENTRY    = 32'h1C00_F000;
  localparam logic [31:0] ERA_IN       = 32'h1C00_0100;
  localparam logic [31:0] PC0          = 32'h1C00_0000;
  localparam logic [31:0] PC1          = 32'h1C00_0004;

  typedef struct packed {
    logic [31:0] target;
    logic [31:0] era;
    logic [3:0]  ecode;
    logic        excp;
    logic        ertn;
    logic        chk_ecode;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  core_excp_ctrl_if #(.LANES(LANES), .EXCP_W(EXCP_W)) bus ();

  core_excp_ctrl #(
    .LANES        (LANES),
    .EXCP_W       (EXCP_W),
    .TLBR_BIT     (14),
    .ITLBR_BIT    (15),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    bus.valid_i       = '0;
    bus.excp_i        = '0;
    bus.ertn_i        = '0;
    bus.idle_i        = '0;
    bus.pc_i[0]       = PC0;
    bus.pc_i[1]       = PC1;
    bus.eentry_i      = EENTRY;
    bus.tlbrentry_i   = TLBRENTRY;
    bus.era_i         = ERA_IN;
    bus.int_pending_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] t, input logic [31:0] e, input logic [3:0] ec,
                      input logic x, input logic r, input logic ce);
    exp_t it;
    it = '{target: t, era: e, ecode: ec, excp: x, ertn: r, chk_ecode: ce};
    sb_q.push_back(it);
  endtask

  // Advance one edge; any redirect pulse is matched against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.redirect_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_redirect", 64'(bus.redirect_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("target", 64'(bus.target_o), 64'(e.target));
        chk("era", 64'(bus.era_o), 64'(e.era));
        chk("excp_commit", 64'(bus.excp_commit_o), 64'(e.excp));
        chk("ertn_commit", 64'(bus.ertn_commit_o), 64'(e.ertn));
        if (e.chk_ecode) chk("ecode_idx", 64'(bus.ecode_idx_o), 64'(e.ecode));
      end
    end
  endtask

  task automatic mask_at_neg(input string tag, input logic [1:0] exp);
    @(negedge clk);
    chk(tag, 64'(bus.commit_mask_o), 64'(exp));
  endtask

  // Trigger edge: the pulse must appear exactly one cycle later
  task automatic trap_tick(input string tag);
    tick();
    chk({tag, "_redirect"}, 64'(bus.redirect_o), 64'd1);
  endtask

  // FLUSH blocks commit and ignores trapping inputs for FLUSH_CYCLES cycles
  task automatic flush_pass(input string tag);
    for (int i = 0; i < int'(FLUSH_CYCLES); i++) begin
      clr();
      bus.valid_i       = 2'b11;
      bus.excp_i[0]     = 16'h0001;
      bus.int_pending_i = 1'b1;
      mask_at_neg({tag, "_flush_mask"}, 2'b00);
      tick();
      chk({tag, "_flush_noredir"}, 64'(bus.redirect_o), 64'd0);
    end
    clr();
    bus.valid_i = 2'b11;
    mask_at_neg({tag, "_back_to_run"}, 2'b11);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_redirect"}, 64'(bus.redirect_o), 64'd0);
    chk({tag, "_excp_commit"}, 64'(bus.excp_commit_o), 64'd0);
    chk({tag, "_ertn_commit"}, 64'(bus.ertn_commit_o), 64'd0);
    chk({tag, "_idle"}, 64'(bus.idle_o), 64'd0);
    chk({tag, "_target"}, 64'(bus.target_o), 64'd0);
    chk({tag, "_era"}, 64'(bus.era_o), 64'd0);
    chk({tag, "_ecode"}, 64'(bus.ecode_idx_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_mask", 64'(bus.commit_mask_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Younger lane exception: older lane commits
    clr();
    bus.valid_i   = 2'b11;
    bus.excp_i[1] = 16'h0008;
    push(EENTRY, PC1, 4'd3, 1'b1, 1'b0, 1'b1);
    mask_at_neg("lane1_excp_mask", 2'b01);
    trap_tick("lane1_excp");
    flush_pass("lane1_excp");

    // No trap: everything valid commits
    clr();
    bus.valid_i = 2'b10;
    mask_at_neg("clean_mask_10", 2'b10);
    tick();
    chk("clean_noredir", 64'(bus.redirect_o), 64'd0);

    // ITLB refill on lane 0 beats the ertn on lane 1
    clr();
    bus.valid_i   = 2'b11;
    bus.excp_i[0] = 16'h8000;
    bus.ertn_i[1] = 1'b1;
    push(TLBRENTRY, PC0, 4'd15, 1'b1, 1'b0, 1'b1);
    mask_at_neg("itlbr_mask", 2'b00);
    trap_tick("itlbr");
    flush_pass("itlbr");

    // ertn on lane 0 commits itself and returns to era_i
    clr();
    bus.valid_i   = 2'b11;
    bus.ertn_i[0] = 1'b1;
    push(ERA_IN, PC0, 4'd0, 1'b0, 1'b1, 1'b0);
    mask_at_neg("ertn0_mask", 2'b01);
    trap_tick("ertn0");
    flush_pass("ertn0");

    // ertn on lane 1 behind a clean lane 0
    clr();
    bus.valid_i   = 2'b11;
    bus.ertn_i[1] = 1'b1;
    push(ERA_IN, PC1, 4'd0, 1'b0, 1'b1, 1'b0);
    mask_at_neg("ertn1_mask", 2'b11);
    trap_tick("ertn1");
    flush_pass("ertn1");

    // Interrupt overrides lane 0's own ertn
    clr();
    bus.valid_i       = 2'b11;
    bus.ertn_i[0]     = 1'b1;
    bus.int_pending_i = 1'b1;
    push(EENTRY, PC0, 4'd15, 1'b1, 1'b0, 1'b1);
    mask_at_neg("int_mask", 2'b00);
    trap_tick("int");
    flush_pass("int");

    // Excepting ertn is an exception; TLBR flag selects refill entry
    clr();
    bus.valid_i   = 2'b01;
    bus.excp_i[0] = 16'h4000;
    bus.ertn_i[0] = 1'b1;
    push(TLBRENTRY, PC0, 4'd14, 1'b1, 1'b0, 1'b1);
    mask_at_neg("tlbr_ertn_mask", 2'b00);
    trap_tick("tlbr_ertn");
    flush_pass("tlbr_ertn");

    // Idle with a flag set is treated as an exception
    clr();
    bus.valid_i   = 2'b01;
    bus.idle_i[0] = 1'b1;
    bus.excp_i[0] = 16'h0004;
    push(EENTRY, PC0, 4'd2, 1'b1, 1'b0, 1'b1);
    mask_at_neg("idle_excp_mask", 2'b00);
    trap_tick("idle_excp");
    chk("idle_excp_idle", 64'(bus.idle_o), 64'd0);
    flush_pass("idle_excp");

    // Idle, then interrupt five cycles later
    clr();
    bus.valid_i   = 2'b11;
    bus.idle_i[0] = 1'b1;
    bus.pc_i[0]   = 32'h1C00_00FC;
    mask_at_neg("idle_mask", 2'b01);
    tick();
    chk("idle_enter", 64'(bus.idle_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      clr();
      bus.valid_i   = 2'b11;
      bus.excp_i[1] = 16'h0008;
      mask_at_neg("idle_wait_mask", 2'b00);
      tick();
      chk("idle_wait", 64'(bus.idle_o), 64'd1);
    end
    clr();
    bus.int_pending_i = 1'b1;
    push(EENTRY, 32'h1C00_0100, 4'd15, 1'b1, 1'b0, 1'b1);
    mask_at_neg("idle_int_mask", 2'b00);
    trap_tick("idle_int");
    chk("idle_exit", 64'(bus.idle_o), 64'd0);
    flush_pass("idle_int");

    // Idle pc+4 wraps modulo 2^32
    clr();
    bus.valid_i   = 2'b01;
    bus.idle_i[0] = 1'b1;
    bus.pc_i[0]   = 32'hFFFF_FFFC;
    mask_at_neg("idle_wrap_mask", 2'b01);
    tick();
    chk("idle_wrap_enter", 64'(bus.idle_o), 64'd1);
    clr();
    bus.int_pending_i = 1'b1;
    push(EENTRY, 32'h0000_0000, 4'd15, 1'b1, 1'b0, 1'b1);
    mask_at_neg("idle_wrap_int_mask", 2'b00);
    trap_tick("idle_wrap");
    flush_pass("idle_wrap");

    // Reset during FLUSH clears everything; first cycle afterwards is RUN
    clr();
    bus.valid_i   = 2'b11;
    bus.excp_i[1] = 16'h0008;
    push(EENTRY, PC1, 4'd3, 1'b1, 1'b0, 1'b1);
    mask_at_neg("pre_rst_mask", 2'b01);
    trap_tick("pre_rst");
    rst = 1'b1;
    #1;
    chk_all_zero("rst_flush");
    chk("rst_flush_mask", 64'(bus.commit_mask_o), 64'd1);
    tick();
    @(negedge clk);
    rst = 1'b0;
    clr();
    bus.valid_i = 2'b11;
    #1;
    chk("post_rst_run_mask", 64'(bus.commit_mask_o), 64'd3);
    tick();

    // Reset before the redirect edge drops the pending pulse
    clr();
    bus.valid_i   = 2'b01;
    bus.excp_i[0] = 16'h0020;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_drop_redirect", 64'(bus.redirect_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    tick();
    chk("rst_drop_after", 64'(bus.redirect_o), 64'd0);

    // Normal trap still works after reset
    clr();
    bus.valid_i   = 2'b01;
    bus.excp_i[0] = 16'h0020;
    push(EENTRY, PC0, 4'd5, 1'b1, 1'b0, 1'b1);
    mask_at_neg("post_rst_trap_mask", 2'b00);
    trap_tick("post_rst_trap");
    flush_pass("post_rst_trap");

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("int_ecode_const", 64'(INT_ECODE_IDX), 64'(bus.ecode_idx_o) | 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
